// File: rtl/run_monitor_pkg.sv
// rtl/run_monitor_pkg.sv - shared state encoding and mailbox constants for run_monitor
package run_monitor_pkg;

   typedef enum logic [2:0] {
      HOLD,
      RUN,
      PASS,
      FAIL,
      TIMEOUT
   } run_state_t;

   // tohost word: bit 0 set means the test finished; value 1 means success
   localparam logic [31:0] PASS_CODE = 32'd1;

   function automatic logic is_terminal(input run_state_t s);
      return (s == PASS) || (s == FAIL) || (s == TIMEOUT);
   endfunction

endpackage

// File: rtl/run_monitor_status_lamps.sv
// rtl/run_monitor_status_lamps.sv - state to heartbeat LED and active-low RGB decode
module status_lamps
   import run_monitor_pkg::*;
(
   input  run_state_t state,
   input  logic       hb,
   output logic       LED,
   output logic       RGB_R,
   output logic       RGB_G,
   output logic       RGB_B
);

   always_comb begin
      LED   = 1'b0;
      RGB_R = 1'b1;
      RGB_G = 1'b1;
      RGB_B = 1'b1;
      case (state)
         HOLD:    RGB_B = 1'b0;
         RUN: begin
            LED   = hb;
            RGB_B = 1'b0;
         end
         PASS: begin
            LED   = 1'b1;
            RGB_G = 1'b0;
         end
         FAIL:    RGB_R = 1'b0;
         TIMEOUT: begin
            RGB_R = 1'b0;
            RGB_B = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/run_monitor.sv
// rtl/run_monitor.sv - holds the core in reset, then watches tohost stores for a pass/fail/timeout verdict
module run_monitor
   import run_monitor_pkg::*;
#(
   parameter int                RESET_CYCLES   = 16,
   parameter int                TIMEOUT_CYCLES = 400,
   parameter int                CNT_W          = 32,
   parameter int                ADDR_W         = 32,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(32'h0000_0FFC),
   parameter int                HB_BIT         = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              st_valid,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [31:0]       st_data,
   output logic              core_rst_n,
   output logic              done,
   output logic              pass,
   output logic [30:0]       fail_code,
   output logic [CNT_W-1:0]  cycle_count,
   output logic              LED,
   output logic              RGB_R,
   output logic              RGB_G,
   output logic              RGB_B
);

   localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   generate
      if ((64'(TIMEOUT_CYCLES) >> CNT_W) != 64'd0) begin : g_timeout_too_wide
         $error("TIMEOUT_CYCLES must be below 2**CNT_W");
      end
   endgenerate

   run_state_t       state_q, state_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [30:0]      fail_q, fail_d;
   logic             hit;
   logic             led_d, rgb_r_d, rgb_g_d, rgb_b_d;

   assign hit = st_valid && (st_addr == TOHOST_ADDR) && st_data[0];

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      fail_d  = fail_q;
      case (state_q)
         HOLD: begin
            if (hold_q == HW'(RESET_CYCLES - 1))
               state_d = RUN;
            else
               hold_d = hold_q + HW'(1);
         end
         RUN: begin
            if (cnt_q != '1)
               cnt_d = cnt_q + CNT_W'(1);
            // a mailbox hit outranks a timeout landing on the same cycle
            if (hit && (st_data == PASS_CODE))
               state_d = PASS;
            else if (hit) begin
               state_d = FAIL;
               fail_d  = st_data[31:1];
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))
               state_d = TIMEOUT;
         end
         default: ;
      endcase
   end

   status_lamps u_lamps (
      .state (state_d),
      .hb    (cnt_d[HB_BIT]),
      .LED   (led_d),
      .RGB_R (rgb_r_d),
      .RGB_G (rgb_g_d),
      .RGB_B (rgb_b_d)
   );

   // outputs are registered from the next-state decode so they line up with the state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= HOLD;
         hold_q     <= '0;
         cnt_q      <= '0;
         fail_q     <= '0;
         core_rst_n <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         LED        <= 1'b0;
         RGB_R      <= 1'b1;
         RGB_G      <= 1'b1;
         RGB_B      <= 1'b1;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         cnt_q      <= cnt_d;
         fail_q     <= fail_d;
         core_rst_n <= (state_d == RUN);
         done       <= is_terminal(state_d);
         pass       <= (state_d == PASS);
         LED        <= led_d;
         RGB_R      <= rgb_r_d;
         RGB_G      <= rgb_g_d;
         RGB_B      <= rgb_b_d;
      end
   end

   assign cycle_count = cnt_q;
   assign fail_code   = fail_q;

endmodule
